// File: rtl/dig_clock_period_meter_pkg.sv
// dig_clock_meter_pkg: state type and default parameters for the clock period meter
package dig_clock_meter_pkg;
  typedef enum logic [0:0] {IDLE, MEASURE} meter_state_t;
  localparam int METER_CNT_W_DEF   = 32;
  localparam int METER_TIMEOUT_DEF = 1048576;
endpackage

// File: rtl/dig_clock_period_meter_if.sv
// dig_clock_period_meter_if: measured signal in, measurement results out
interface dig_clock_period_meter_if #(parameter int CNT_W = 32);
  logic             sig;
  logic [CNT_W-1:0] halfPeriod;
  logic [CNT_W-1:0] divisor;
  logic             valid;
  logic             locked;
  logic             timeout;
  modport master (output sig, input halfPeriod, divisor, valid, locked, timeout);
  modport slave  (input sig, output halfPeriod, divisor, valid, locked, timeout);
endinterface

// File: rtl/dig_clock_period_meter_edge_sync.sv
// dig_edge_sync: samples sig into cin and flags either transition; CLOCK_METER_SYNC_EN adds a 2-flop synchronizer
module dig_edge_sync (
  input  logic cin,
  input  logic rst,
  input  logic i_sig,
  output logic o_edge
);
  logic r_cur, r_prev;
`ifdef CLOCK_METER_SYNC_EN
  logic r_s1;
  always_ff @(posedge cin) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_sig;
      r_cur  <= r_s1;
      r_prev <= r_cur;
    end
  end
`else
  always_ff @(posedge cin) begin
    if (rst) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= i_sig;
      r_prev <= r_cur;
    end
  end
`endif
  assign o_edge = r_cur ^ r_prev;
endmodule

// File: rtl/dig_clock_period_meter.sv
// dig_clock_period_meter: measures cin cycles between sig edges and recovers the divider setting (CLOCK_METER_SYNC_EN selects synchronized input)
module dig_clock_period_meter import dig_clock_meter_pkg::*; #(
  parameter int CNT_W   = METER_CNT_W_DEF,
  parameter int TIMEOUT = METER_TIMEOUT_DEF
) (
  input logic                      cin,
  input logic                      rst,
  dig_clock_period_meter_if.slave  bus
);
  meter_state_t     r_state;
  logic [CNT_W-1:0] r_cnt, r_hp, r_div, w_cnt_inc;
  logic             r_valid, r_locked, r_timeout, r_first, w_edge;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  dig_edge_sync u_sync (
    .cin    (cin),
    .rst    (rst),
    .i_sig  (bus.sig),
    .o_edge (w_edge)
  );
  // r_first keeps a stale pre-timeout halfPeriod from producing a false lock
  always_ff @(posedge cin) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hp      <= '0;
      r_div     <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
      r_first   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_edge) begin
          r_cnt     <= '0;
          r_state   <= MEASURE;
          r_timeout <= 1'b0;
          r_first   <= 1'b1;
        end
      end else if (w_edge) begin
        r_hp     <= w_cnt_inc;
        r_div    <= r_cnt;
        r_valid  <= 1'b1;
        r_cnt    <= '0;
        r_locked <= !r_first && (w_cnt_inc == r_hp);
        r_first  <= 1'b0;
      end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
        r_state   <= IDLE;
        r_timeout <= 1'b1;
        r_locked  <= 1'b0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end
  assign bus.halfPeriod = r_hp;
  assign bus.divisor    = r_div;
  assign bus.valid      = r_valid;
  assign bus.locked     = r_locked;
  assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_dig_clock_period_meter.sv
// tb_dig_clock_period_meter: table-driven edge sequences with a scoreboard of expected measurements
module tb_dig_clock_period_meter;
  localparam int W  = 32;
  localparam int TO = 16;
`ifdef CLOCK_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {int gap; bit v; logic [31:0] hp; bit lk;} vec_t;
  typedef struct {logic [31:0] hp; bit lk; int at;} exp_t;
  logic cin = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  vec_t tbl[11];
  dig_clock_period_meter_if #(.CNT_W(W)) bus ();
  dig_clock_period_meter #(.CNT_W(W), .TIMEOUT(TO)) dut (.cin(cin), .rst(rst), .bus(bus));
  always #5 cin = ~cin;
  always @(posedge cin) cyc <= cyc + 1;
  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic zeros(string n);
    check({n, "_halfPeriod"}, bus.halfPeriod, 0);
    check({n, "_divisor"}, bus.divisor, 0);
    check({n, "_valid"}, {31'd0, bus.valid}, 0);
    check({n, "_locked"}, {31'd0, bus.locked}, 0);
    check({n, "_timeout"}, {31'd0, bus.timeout}, 0);
  endtask
  task automatic toggle(int gap, bit v, logic [31:0] hp, bit lk);
    exp_t e;
    repeat (gap) @(posedge cin);
    #1 bus.sig = ~bus.sig;
    if (v) begin
      e.hp = hp;
      e.lk = lk;
      e.at = cyc + 1 + LAT;
      q.push_back(e);
    end
  endtask
  always @(negedge cin) begin
    exp_t e;
    if (!rst && bus.valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 required=0 halfPeriod=%0d (cycle %0d)", bus.halfPeriod, cyc);
      end else begin
        e = q.pop_front();
        check("valid_cycle", cyc, e.at);
        check("halfPeriod", bus.halfPeriod, e.hp);
        check("divisor", bus.divisor, e.hp - 1);
        check("locked", {31'd0, bus.locked}, {31'd0, e.lk});
        check("timeout_on_valid", {31'd0, bus.timeout}, 0);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
  initial begin
    tbl[0]  = '{3,  1'b0, 0,  1'b0};
    tbl[1]  = '{5,  1'b1, 5,  1'b0};
    tbl[2]  = '{5,  1'b1, 5,  1'b1};
    tbl[3]  = '{5,  1'b1, 5,  1'b1};
    tbl[4]  = '{5,  1'b1, 5,  1'b1};
    tbl[5]  = '{7,  1'b1, 7,  1'b0};
    tbl[6]  = '{10, 1'b1, 10, 1'b0};
    tbl[7]  = '{10, 1'b1, 10, 1'b1};
    tbl[8]  = '{10, 1'b1, 10, 1'b1};
    tbl[9]  = '{16, 1'b1, 16, 1'b0};
    tbl[10] = '{16, 1'b1, 16, 1'b1};
    bus.sig = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge cin);
    #1 rst = 1'b0;
    @(negedge cin);
    zeros("reset");
    for (int i = 0; i < 11; i++) toggle(tbl[i].gap, tbl[i].v, tbl[i].hp, tbl[i].lk);
    repeat (LAT + 16) @(posedge cin);
    @(negedge cin);
    check("timeout_early", {31'd0, bus.timeout}, 0);
    @(negedge cin);
    check("timeout_rise", {31'd0, bus.timeout}, 1);
    check("locked_on_timeout", {31'd0, bus.locked}, 0);
    check("halfPeriod_hold", bus.halfPeriod, 16);
    check("divisor_hold", bus.divisor, 15);
    toggle(3, 1'b0, 0, 1'b0);
    repeat (LAT) @(posedge cin);
    @(negedge cin);
    check("timeout_before_latency", {31'd0, bus.timeout}, 1);
    @(negedge cin);
    check("timeout_clear", {31'd0, bus.timeout}, 0);
    check("no_valid_on_restart", {31'd0, bus.valid}, 0);
    toggle(16 - LAT - 1, 1'b1, 16, 1'b0);
    toggle(16, 1'b1, 16, 1'b1);
    repeat (8) @(posedge cin);
    @(negedge cin);
    check("locked_before_rst", {31'd0, bus.locked}, 1);
    @(posedge cin);
    #1 rst = 1'b1;
    bus.sig = 1'b0;
    @(posedge cin);
    #1 rst = 1'b0;
    @(negedge cin);
    zeros("after_rst");
    toggle(3, 1'b0, 0, 1'b0);
    toggle(6, 1'b1, 6, 1'b0);
    toggle(6, 1'b1, 6, 1'b1);
    repeat (10) @(posedge cin);
    @(negedge cin);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
